// File: rtl/mod_n_counter.sv
// mod_n_counter: loadable modulo-N up/down counter.
// Q counts through 0 .. MODULUS-1 in either direction and wraps at both ends.
// TC is combinational so that stages can be cascaded without added latency.
// LoadErr is a sticky record of any attempted load with P >= MODULUS.
// The embedded checker module below is instantiated by the counter, so every
// placement of the counter carries its own property checks.

// Property checker for mod_n_counter; observes the counter ports only.
module mod_n_counter_chk #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input logic             CLK,
  input logic             MR,
  input logic             Load,
  input logic [WIDTH-1:0] P,
  input logic             Enable,
  input logic             Up,
  input logic [WIDTH-1:0] Q,
  input logic             LoadErr
);

  localparam logic [WIDTH:0] MOD_W = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH:0] MAX_W = (WIDTH+1)'(MODULUS - 1);

  logic [WIDTH:0] p_ext_s;
  logic [WIDTH:0] q_ext_s;

  assign p_ext_s = {1'b0, P};
  assign q_ext_s = {1'b0, Q};

  a1_load_ok : assert property (@(posedge CLK) disable iff (MR)
    (Load && (p_ext_s < MOD_W)) |=> (Q == $past(P)))
    else $error("A1 load_ok: Q does not equal the loaded value");

  a2_load_bad : assert property (@(posedge CLK) disable iff (MR)
    (Load && (p_ext_s >= MOD_W)) |=> ((Q == $past(Q)) && LoadErr))
    else $error("A2 load_bad: Q changed or LoadErr not set on out-of-range load");

  a3_wrap_up : assert property (@(posedge CLK) disable iff (MR)
    (!Load && Enable && Up && (q_ext_s == MAX_W)) |=> (Q == {WIDTH{1'b0}}))
    else $error("A3 wrap_up: Q did not wrap from MODULUS-1 to 0");

  a4_wrap_down : assert property (@(posedge CLK) disable iff (MR)
    (!Load && Enable && !Up && (q_ext_s == {(WIDTH+1){1'b0}})) |=> (q_ext_s == MAX_W))
    else $error("A4 wrap_down: Q did not wrap from 0 to MODULUS-1");

  a5_hold : assert property (@(posedge CLK) disable iff (MR)
    (!Load && !Enable) |=> $stable(Q))
    else $error("A5 hold: Q changed while idle");

  a6_range : assert property (@(posedge CLK) disable iff (MR)
    (q_ext_s < MOD_W))
    else $error("A6 range: Q is not below MODULUS");

  a7_err_cause : assert property (@(posedge CLK) disable iff (MR)
    $rose(LoadErr) |-> $past(Load && (p_ext_s >= MOD_W)))
    else $error("A7 err_cause: LoadErr rose without an out-of-range load");

  a8_err_sticky : assert property (@(posedge CLK) disable iff (MR)
    LoadErr |=> LoadErr)
    else $error("A8 err_sticky: LoadErr cleared without MR");

endmodule

// Modulo-N counter top level.
module mod_n_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             CLK,
  input  logic             MR,
  input  logic             Load,
  input  logic [WIDTH-1:0] P,
  input  logic             Enable,
  input  logic             Up,
  output logic [WIDTH-1:0] Q,
  output logic             TC,
  output logic             LoadErr
);

  // Reject moduli that cannot be represented or cannot count.
  if ((MODULUS < 2) || (MODULUS > (1 << WIDTH))) begin : g_bad_modulus
    $fatal(1, "mod_n_counter: MODULUS %0d illegal for WIDTH %0d", MODULUS, WIDTH);
  end

  // All range arithmetic is done one bit wider than Q so that
  // MODULUS == 2**WIDTH is representable and overflow is visible.
  localparam logic [WIDTH:0] MOD_W = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH:0] MAX_W = (WIDTH+1)'(MODULUS - 1);

  logic [WIDTH-1:0] q_r;
  logic             err_r;

  logic [WIDTH:0]   q_ext_s;
  logic [WIDTH:0]   p_ext_s;
  logic             p_ok_s;
  logic             at_max_s;
  logic             at_zero_s;
  logic [WIDTH:0]   step_s;
  logic [WIDTH-1:0] q_next_s;
  logic             err_next_s;
  logic             tc_s;

  assign q_ext_s   = {1'b0, q_r};
  assign p_ext_s   = {1'b0, P};
  assign p_ok_s    = (p_ext_s < MOD_W);
  assign at_max_s  = (q_ext_s == MAX_W);
  assign at_zero_s = (q_ext_s == {(WIDTH+1){1'b0}});

  // One count step in the selected direction, wrapping at either end.
  always_comb begin
    step_s = q_ext_s;
    if (Up) begin
      if (at_max_s) begin
        step_s = {(WIDTH+1){1'b0}};
      end else begin
        step_s = q_ext_s + (WIDTH+1)'(1);
      end
    end else begin
      if (at_zero_s) begin
        step_s = MAX_W;
      end else begin
        step_s = q_ext_s - (WIDTH+1)'(1);
      end
    end
  end

  // Next-state selection: Load has priority over Enable, otherwise hold.
  always_comb begin
    q_next_s   = q_r;
    err_next_s = err_r;
    if (Load) begin
      if (p_ok_s) begin
        q_next_s = P;
      end else begin
        // Illegal value: keep Q, record the attempt, do not count.
        q_next_s   = q_r;
        err_next_s = 1'b1;
      end
    end else if (Enable) begin
      // Out-of-range guard: Q can never be driven to MODULUS or above.
      if (step_s < MOD_W) begin
        q_next_s = step_s[WIDTH-1:0];
      end else begin
        q_next_s = {WIDTH{1'b0}};
      end
    end else begin
      q_next_s = q_r;
    end
  end

  // Terminal count: high in the cycle whose next edge wraps Q.
  always_comb begin
    tc_s = 1'b0;
    if (MR) begin
      tc_s = 1'b0;
    end else if (Enable && !Load) begin
      tc_s = Up ? at_max_s : at_zero_s;
    end else begin
      tc_s = 1'b0;
    end
  end

  // Count and sticky-error registers, cleared asynchronously by MR.
  always_ff @(posedge CLK or posedge MR) begin
    if (MR) begin
      q_r   <= {WIDTH{1'b0}};
      err_r <= 1'b0;
    end else begin
      q_r   <= q_next_s;
      err_r <= err_next_s;
    end
  end

  assign Q       = q_r;
  assign TC      = tc_s;
  assign LoadErr = err_r;

  mod_n_counter_chk #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS)
  ) u_chk (
    .CLK     (CLK),
    .MR      (MR),
    .Load    (Load),
    .P       (P),
    .Enable  (Enable),
    .Up      (Up),
    .Q       (q_r),
    .LoadErr (err_r)
  );

endmodule

// File: tb/tb_mod_n_counter.sv
// tb_mod_n_counter: scoreboard bench for mod_n_counter.
// Instances: main (4 bits, mod 10), power-of-two (3 bits, mod 8), and a
// two-digit cascade (mod 10 each). Expected values are pushed when stimulus
// is driven and popped after the edge that produces them.
module tb_mod_n_counter;

  logic       CLK = 1'b0;
  logic       mr;

  logic       load;
  logic [3:0] p;
  logic       en;
  logic       up;
  logic [3:0] q;
  logic       tc;
  logic       lerr;

  logic       p2_load;
  logic [2:0] p2_p;
  logic       p2_en;
  logic       p2_up;
  logic [2:0] p2_q;
  logic       p2_tc;
  logic       p2_err;

  logic       cas_en;
  logic [3:0] lo_q;
  logic [3:0] hi_q;
  logic       lo_tc;
  logic       hi_tc;
  logic       lo_err;
  logic       hi_err;

  typedef struct {
    int          sel;
    string       tag;
    logic [31:0] exp;
  } sb_t;

  sb_t sb_q[$];

  int n_cmp = 0;
  int n_err = 0;

  // Reference state for the main instance.
  int m_q   = 0;
  int m_err = 0;

  always #5 CLK = ~CLK;

  mod_n_counter #(.WIDTH(4), .MODULUS(10)) u_dut (
    .CLK(CLK), .MR(mr), .Load(load), .P(p), .Enable(en), .Up(up),
    .Q(q), .TC(tc), .LoadErr(lerr)
  );

  mod_n_counter #(.WIDTH(3), .MODULUS(8)) u_p2 (
    .CLK(CLK), .MR(mr), .Load(p2_load), .P(p2_p), .Enable(p2_en), .Up(p2_up),
    .Q(p2_q), .TC(p2_tc), .LoadErr(p2_err)
  );

  mod_n_counter #(.WIDTH(4), .MODULUS(10)) u_lo (
    .CLK(CLK), .MR(mr), .Load(1'b0), .P(4'd0), .Enable(cas_en), .Up(1'b1),
    .Q(lo_q), .TC(lo_tc), .LoadErr(lo_err)
  );

  mod_n_counter #(.WIDTH(4), .MODULUS(10)) u_hi (
    .CLK(CLK), .MR(mr), .Load(1'b0), .P(4'd0), .Enable(lo_tc), .Up(1'b1),
    .Q(hi_q), .TC(hi_tc), .LoadErr(hi_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int sel, input string tag, input logic [31:0] exp);
    sb_t e;
    e.sel = sel;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  // Compare every queued expectation against the current DUT outputs.
  task automatic drain();
    sb_t         e;
    logic [31:0] obs;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      case (e.sel)
        0:       obs = {28'd0, q};
        1:       obs = {31'd0, lerr};
        2:       obs = {29'd0, p2_q};
        3:       obs = {24'd0, hi_q, lo_q};
        default: obs = 32'hxxxx_xxxx;
      endcase
      chk(e.tag, obs, e.exp);
    end
  endtask

  // One cycle on the main instance: TC checked before the edge, Q/LoadErr after.
  task automatic drive(input logic l, input logic [3:0] pv, input logic e, input logic u);
    int exp_tc;
    load = l; p = pv; en = e; up = u;
    #1;
    exp_tc = (e && !l && (u ? (m_q == 9) : (m_q == 0))) ? 1 : 0;
    chk("tc", {31'd0, tc}, exp_tc);
    if (l) begin
      if (pv < 10) m_q = pv;
      else         m_err = 1;
    end else if (e) begin
      if (u) m_q = (m_q == 9) ? 0 : m_q + 1;
      else   m_q = (m_q == 0) ? 9 : m_q - 1;
    end
    push(0, "q", m_q);
    push(1, "load_err", m_err);
    @(posedge CLK);
    #1;
    drain();
  endtask

  // Asynchronous reset between edges; outputs must clear before any edge.
  task automatic do_reset();
    load = 1'b0; en = 1'b0; up = 1'b1;
    mr = 1'b1;
    #1;
    m_q = 0; m_err = 0;
    chk("rst_q", {28'd0, q}, 32'd0);
    chk("rst_err", {31'd0, lerr}, 32'd0);
    @(posedge CLK);
    #1;
    mr = 1'b0;
  endtask

  task automatic p2_drive(input logic l, input logic [2:0] pv, input logic e, input logic u,
                          input int exp_q, input int exp_tc);
    p2_load = l; p2_p = pv; p2_en = e; p2_up = u;
    #1;
    chk("p2_tc", {31'd0, p2_tc}, exp_tc);
    push(2, "p2_q", exp_q);
    @(posedge CLK);
    #1;
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int tc_cnt;
    mr = 1'b1;
    load = 1'b0; p = 4'd0; en = 1'b0; up = 1'b1;
    p2_load = 1'b0; p2_p = 3'd0; p2_en = 1'b0; p2_up = 1'b1;
    cas_en = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    // TC must stay low under reset even when the down-wrap condition holds.
    en = 1'b1; up = 1'b0;
    #1;
    chk("reset_q", {28'd0, q}, 32'd0);
    chk("reset_err", {31'd0, lerr}, 32'd0);
    chk("reset_tc", {31'd0, tc}, 32'd0);
    en = 1'b0; up = 1'b1;
    @(posedge CLK);
    #1;
    mr = 1'b0;

    // Count to 6, then reset mid-count and resume.
    repeat (6) drive(1'b0, 4'd0, 1'b1, 1'b1);
    do_reset();
    drive(1'b0, 4'd0, 1'b1, 1'b1);

    // Legal and illegal loads; error flag sticky until MR.
    drive(1'b1, 4'd5, 1'b0, 1'b1);
    drive(1'b1, 4'd12, 1'b0, 1'b1);
    drive(1'b1, 4'd15, 1'b1, 1'b1);
    repeat (3) drive(1'b0, 4'd0, 1'b1, 1'b1);
    drive(1'b1, 4'd2, 1'b0, 1'b1);
    do_reset();

    // Wrap upward, wrap downward, direction flip on the wrap edge.
    drive(1'b1, 4'd8, 1'b0, 1'b1);
    drive(1'b0, 4'd0, 1'b1, 1'b1);
    drive(1'b0, 4'd0, 1'b1, 1'b1);
    drive(1'b1, 4'd1, 1'b0, 1'b0);
    drive(1'b0, 4'd0, 1'b1, 1'b0);
    drive(1'b0, 4'd0, 1'b1, 1'b0);
    drive(1'b0, 4'd0, 1'b1, 1'b1);
    drive(1'b0, 4'd0, 1'b1, 1'b0);

    // Load beats Enable; idle cycles hold Q regardless of Up.
    drive(1'b1, 4'd7, 1'b0, 1'b1);
    drive(1'b1, 4'd3, 1'b1, 1'b1);
    for (int i = 0; i < 15; i++) drive(1'b0, 4'd0, 1'b0, 1'($urandom_range(0, 1)));

    // Random mix against the reference.
    for (int i = 0; i < 150; i++) begin
      drive(($urandom_range(0, 7) == 0), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    do_reset();

    // Power-of-two modulus: natural overflow equals the wrap.
    p2_drive(1'b1, 3'd6, 1'b0, 1'b1, 6, 0);
    p2_drive(1'b0, 3'd0, 1'b1, 1'b1, 7, 0);
    p2_drive(1'b0, 3'd0, 1'b1, 1'b1, 0, 1);
    p2_drive(1'b0, 3'd0, 1'b1, 1'b1, 1, 0);
    p2_drive(1'b0, 3'd0, 1'b1, 1'b0, 0, 0);
    p2_drive(1'b0, 3'd0, 1'b1, 1'b0, 7, 1);
    p2_drive(1'b1, 3'd7, 1'b1, 1'b1, 7, 0);
    p2_en = 1'b0; p2_load = 1'b0;
    chk("p2_err", {31'd0, p2_err}, 32'd0);

    // Two-digit cascade through 100 counts.
    do_reset();
    cas_en = 1'b1;
    tc_cnt = 0;
    for (int k = 1; k <= 100; k++) begin
      if (hi_tc) tc_cnt++;
      push(3, "cascade", ((k / 10) % 10) * 16 + (k % 10));
      @(posedge CLK);
      #1;
      drain();
    end
    cas_en = 1'b0;
    chk("hi_tc_pulses", tc_cnt, 32'd1);
    chk("cascade_err", {30'd0, hi_err, lo_err}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
